count_datapath: RTL and testbench
=================================

COUNT_DATAPATH -- requirements
Module: count_datapath

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, clk cycles per 10 ms time tick (minimum 2).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles per display digit slot (minimum 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clr  input  1  clear running time, lap register, prescaler, ovf, lap_valid.
REQ-006 count  input  1  run enable for prescaler and time counter.
REQ-007 save  input  1  capture running time into lap register.
REQ-008 disp  input  1  display select: 1 = lap register, 0 = running time.
REQ-009 time_bcd  output  16  displayed value, BCD {S tens, S units, h tens, h units}.
REQ-010 lap_valid  output  1  lap register holds a captured value.
REQ-011 ovf  output  1  sticky flag: running time wrapped since last clr.
REQ-012 an  output  4  active-low digit enables; an[0] = hundredths units.
REQ-013 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-014 dp  output  1  active-low decimal point, lit only while an[2] active.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 while count=1, hold while count=0; tick pulse asserts for 1 cycle when prescaler = TICK_DIV-1 and count=1, prescaler returns to 0.
REQ-016 On tick, running time SHALL increment as BCD SS.hh: h units 9->0 carries h tens, h 99->00 carries S units, S 59->00 wraps.
REQ-017 Wrap 59.99->00.00 SHALL set ovf on the same edge; ovf holds until clr or reset.
REQ-018 save=1 SHALL load lap register with running time value before that edge's increment, and set lap_valid; captures every cycle save=1.
REQ-019 clr=1 SHALL zero running time, lap register, prescaler, ovf, lap_valid; clr has priority over count, tick, and save in the same cycle.
REQ-020 time_bcd SHALL be combinational mux: disp=1 -> lap register, disp=0 -> running time; no latency.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 continuously (independent of count/clr), advancing digit index 0->1->2->3->0 at terminal count.
REQ-022 an SHALL be one-hot low for current digit index; seg SHALL be the 7-segment code of the corresponding time_bcd nibble; nibble values 10-15 SHALL display blank (all segments high).
REQ-023 Codes (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-024 reset=1 SHALL zero running time, lap register, prescaler, scan counter, digit index, ovf, lap_valid on the next rising edge; reset overrides all inputs.
REQ-025 After reset: time_bcd=16'h0000, lap_valid=0, ovf=0, an=4'b1110, seg=7'b1000000, dp=1.
REQ-026 Reset mid-count SHALL discard partial prescaler count; first tick after release occurs TICK_DIV cycles after count asserts.

Structure
REQ-027 Shared package SHALL hold the 7-segment code constants, BCD digit width (4), and digit count (4).
REQ-028 The BCD->7-segment decode SHALL be a sub-module named seg7_decode (4-bit in, 7-bit active-low out, combinational); all sequential state stays in count_datapath.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-029 reset, then count=1 for 40 cycles -> time_bcd=16'h0010 (10 ticks), ovf=0.
REQ-030 Preload by running to 59.99, one further tick -> time_bcd=16'h0000, ovf=1; clr=1 one cycle -> ovf=0.
REQ-031 Running at 00.05 with save=1 coincident with tick -> lap=16'h0005, running=16'h0006; disp=1 shows 16'h0005, lap_valid=1.
REQ-032 clr=1 with save=1 and tick in same cycle -> running=0, lap=0, lap_valid=0.
REQ-033 time_bcd=16'h1234, disp=0 -> an sequence 1110,1101,1011,0111 each 2 cycles with seg codes for 4,3,2,1; dp=0 only during an=1011.
REQ-034 count=0 for 20 cycles mid-run -> time_bcd unchanged, prescaler held; resume yields tick after remaining prescaler cycles.

Source files
------------

// File: rtl/count_datapath_pkg.sv
// Shared constants and types for the stopwatch count datapath.
// This covers BCD digit geometry, the active-low 7-segment codes and the BCD time layout.
package count_datapath_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DIG_IDX_W  = $clog2(NUM_DIGITS);

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [BCD_W-1:0] s_tens;
        logic [BCD_W-1:0] s_units;
        logic [BCD_W-1:0] h_tens;
        logic [BCD_W-1:0] h_units;
    } bcd_time_t;

    function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d,
                                                       input logic [BCD_W-1:0] last);
        return (d == last) ? 4'd0 : (d + 4'd1);
    endfunction

endpackage

// File: rtl/count_datapath_if.sv
// Control inputs and display outputs of the stopwatch datapath.
// The clock and reset are outside this bundle.
interface count_datapath_if;
    logic        clr;
    logic        count;
    logic        save;
    logic        disp;
    logic [15:0] time_bcd;
    logic        lap_valid;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output clr, count, save, disp,
        input  time_bcd, lap_valid, ovf, an, seg, dp
    );

    modport slave (
        input  clr, count, save, disp,
        output time_bcd, lap_valid, ovf, an, seg, dp
    );
endinterface

// File: rtl/count_datapath_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal nibble values produce a blank digit.
module seg7_decode
    import count_datapath_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);

    // Nibble to segment pattern lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_datapath.sv
// Stopwatch datapath: 10 ms prescaler, SS.hh BCD running time, lap capture, wrap flag
// and a multiplexed 4-digit active-low 7-segment scan.
module count_datapath
    import count_datapath_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    count_datapath_if.slave  bus
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0]    SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_IDX_W-1:0] DIG_LAST   = DIG_IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]   presc_q, presc_d;
    bcd_time_t            time_q, time_d;
    bcd_time_t            lap_q, lap_d;
    logic                 lap_valid_q, lap_valid_d;
    logic                 ovf_q, ovf_d;
    logic [SCAN_W-1:0]    scan_q, scan_d;
    logic [DIG_IDX_W-1:0] dig_q, dig_d;

    logic                 tick_s;
    bcd_time_t            time_inc_s;
    logic                 c_hu_s, c_ht_s, c_su_s, wrap_s;
    bcd_time_t            time_bcd_s;
    logic [BCD_W-1:0]     nibble_s;
    logic [6:0]           seg_s;
    logic [3:0]           an_s;

    assign tick_s = bus.count && (presc_q == PRESC_LAST);

    // BCD increment of SS.hh with ripple carries; wrap_s marks 59.99 -> 00.00
    always_comb begin
        c_hu_s = (time_q.h_units == 4'd9);
        c_ht_s = c_hu_s && (time_q.h_tens == 4'd9);
        c_su_s = c_ht_s && (time_q.s_units == 4'd9);
        wrap_s = c_su_s && (time_q.s_tens == 4'd5);
        time_inc_s.h_units = bcd_digit_inc(time_q.h_units, 4'd9);
        time_inc_s.h_tens  = c_hu_s ? bcd_digit_inc(time_q.h_tens, 4'd9)  : time_q.h_tens;
        time_inc_s.s_units = c_ht_s ? bcd_digit_inc(time_q.s_units, 4'd9) : time_q.s_units;
        time_inc_s.s_tens  = c_su_s ? bcd_digit_inc(time_q.s_tens, 4'd5)  : time_q.s_tens;
    end

    // Timekeeping next state; clr outranks tick and save, and save latches the pre-tick time
    always_comb begin
        presc_d     = presc_q;
        time_d      = time_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        ovf_d       = ovf_q;
        if (bus.clr) begin
            presc_d     = '0;
            time_d      = '0;
            lap_d       = '0;
            lap_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (tick_s) begin
                presc_d = '0;
                time_d  = time_inc_s;
                ovf_d   = ovf_q | wrap_s;
            end else if (bus.count) begin
                presc_d = presc_q + PRESC_W'(1);
            end else begin
                presc_d = presc_q;
            end
            if (bus.save) begin
                lap_d       = time_q;
                lap_valid_d = 1'b1;
            end else begin
                lap_d       = lap_q;
            end
        end
    end

    // Free-running digit scan, unaffected by clr or count
    always_comb begin
        scan_d = scan_q;
        dig_d  = dig_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            dig_d  = (dig_q == DIG_LAST) ? '0 : (dig_q + DIG_IDX_W'(1));
        end else begin
            scan_d = scan_q + SCAN_W'(1);
            dig_d  = dig_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            time_q      <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            scan_q      <= '0;
            dig_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            ovf_q       <= ovf_d;
            scan_q      <= scan_d;
            dig_q       <= dig_d;
        end
    end

    // Display source select and per-digit nibble / anode selection
    always_comb begin
        time_bcd_s = bus.disp ? lap_q : time_q;
        nibble_s   = time_bcd_s.h_units;
        an_s       = 4'b1110;
        case (dig_q)
            2'd0: begin nibble_s = time_bcd_s.h_units; an_s = 4'b1110; end
            2'd1: begin nibble_s = time_bcd_s.h_tens;  an_s = 4'b1101; end
            2'd2: begin nibble_s = time_bcd_s.s_units; an_s = 4'b1011; end
            2'd3: begin nibble_s = time_bcd_s.s_tens;  an_s = 4'b0111; end
            default: begin nibble_s = time_bcd_s.h_units; an_s = 4'b1110; end
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd_i (nibble_s),
        .seg_o (seg_s)
    );

    assign bus.time_bcd  = time_bcd_s;
    assign bus.lap_valid = lap_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.an        = an_s;
    assign bus.seg       = seg_s;
    // Decimal point sits after the seconds-units digit
    assign bus.dp        = (dig_q != 2'd2);

endmodule

// File: tb/tb_count_datapath.sv
// Randomised and directed scoreboard bench for count_datapath.
// The reference model tracks time as integer hundredths of a second.
module tb_count_datapath;

    localparam int TD = 4;
    localparam int SD = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    count_datapath_if bus();

    count_datapath #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] tbcd;
        logic        lv;
        logic        ovf;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // reference model state
    int m_time = 0;
    int m_lap = 0;
    int m_presc = 0;
    int m_scan = 0;
    bit m_ovf = 1'b0;
    bit m_lv = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    endtask

    // apply one cycle of inputs, advance the model across the coming edge, queue expectation
    task automatic drive(input bit r, input bit c, input bit cnt, input bit s, input bit d);
        exp_t e;
        int   dig;
        logic [15:0] shown;
        @(negedge clk);
        #1;
        reset = r; bus.clr = c; bus.count = cnt; bus.save = s; bus.disp = d;
        if (r) begin
            m_time = 0; m_lap = 0; m_presc = 0; m_scan = 0; m_ovf = 1'b0; m_lv = 1'b0;
        end else begin
            m_scan++;
            if (c) begin
                m_time = 0; m_lap = 0; m_presc = 0; m_ovf = 1'b0; m_lv = 1'b0;
            end else begin
                if (s) begin
                    m_lap = m_time;
                    m_lv  = 1'b1;
                end
                if (cnt) begin
                    if (m_presc == TD - 1) begin
                        m_presc = 0;
                        m_time  = m_time + 1;
                        if (m_time == 6000) begin
                            m_time = 0;
                            m_ovf  = 1'b1;
                        end
                    end else begin
                        m_presc++;
                    end
                end
            end
        end
        dig    = (m_scan / SD) % 4;
        shown  = d ? to_bcd(m_lap) : to_bcd(m_time);
        e.tbcd = shown;
        e.lv   = m_lv;
        e.ovf  = m_ovf;
        e.an   = ~(4'b0001 << dig);
        e.seg  = seg_ref(4'((shown >> (4 * dig)) & 16'h000F));
        e.dp   = (dig != 2);
        exp_q.push_back(e);
    endtask

    // monitor: every negedge the outputs of the preceding edge are compared
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("time_bcd",  bus.time_bcd,          e.tbcd);
            chk("lap_valid", {15'd0, bus.lap_valid}, {15'd0, e.lv});
            chk("ovf",       {15'd0, bus.ovf},       {15'd0, e.ovf});
            chk("an",        {12'd0, bus.an},        {12'd0, e.an});
            chk("seg",       {9'd0, bus.seg},        {9'd0, e.seg});
            chk("dp",        {15'd0, bus.dp},        {15'd0, e.dp});
        end
    end

    initial begin
        bus.clr = 1'b0; bus.count = 1'b0; bus.save = 1'b0; bus.disp = 1'b0;
        reset = 1'b1;

        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 1);
        // ten ticks in forty cycles
        repeat (40) drive(0, 0, 1, 0, 0);
        // run up to 59.99 on the edge before a tick, then wrap, then clear
        while (!(m_time == 5999 && m_presc == TD - 1)) drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // save coincident with the tick at 00.05
        while (!(m_time == 5 && m_presc == TD - 1)) drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        repeat (3) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        // clr beats save and tick in the same cycle
        while (m_presc != TD - 1) drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 1);
        // scan out 12.34, then hold mid-prescale and resume
        while (m_time != 1234) drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        repeat (20) drive(0, 0, 0, 0, 0);
        repeat (12) drive(0, 0, 1, 0, 0);
        // reset mid-count discards the partial prescale
        drive(1, 0, 1, 0, 0);
        repeat (9) drive(0, 0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(499) == 0), ($urandom_range(99) == 0),
                  ($urandom_range(3) != 0), ($urandom_range(15) == 0),
                  ($urandom_range(3) == 0));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
